// File: rtl/orv64_typedef_pkg.sv
// Shared types for the PMP check arbiter: address/access/cause types,
// arbiter FSM states and the fixed requester slot numbering.
package orv64_typedef_pkg;

  typedef logic [55:0] orv64_paddr_t;
  typedef logic [7:0]  cpu_byte_mask_t;
  typedef logic [3:0]  orv64_excp_cause_t;

  typedef enum logic [1:0] {
    ORV64_ACCESS_FETCH = 2'd0,
    ORV64_ACCESS_LOAD  = 2'd1,
    ORV64_ACCESS_STORE = 2'd2
  } orv64_access_type_t;

  // Cause encodings follow the RISC-V mcause numbering for access faults.
  localparam orv64_excp_cause_t ORV64_EXCP_CAUSE_NONE         = 4'd0;
  localparam orv64_excp_cause_t ORV64_EXCP_INST_ACCESS_FAULT  = 4'd1;
  localparam orv64_excp_cause_t ORV64_EXCP_LOAD_ACCESS_FAULT  = 4'd5;
  localparam orv64_excp_cause_t ORV64_EXCP_STORE_ACCESS_FAULT = 4'd7;

  localparam int unsigned ORV64_PMP_REQ_IFU = 0;
  localparam int unsigned ORV64_PMP_REQ_LSU = 1;
  localparam int unsigned ORV64_PMP_REQ_PTW = 2;

  typedef enum logic [1:0] {
    PMP_ARB_IDLE  = 2'd0,
    PMP_ARB_CHECK = 2'd1,
    PMP_ARB_RESP  = 2'd2
  } pmp_arb_state_e;

endpackage

// File: rtl/orv64_rr_arbiter.sv
// Round-robin picker: grants the first requester after last_grant_i,
// wrapping around, as a one-hot vector (zero when nobody requests).
module orv64_rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N_REQ-1:0] grant_o
);

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    grant_o = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_i[i] && (i == ((int'(last_grant_i) + off) % N_REQ))) begin
          grant_o    = '0;
          grant_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/orv64_pmp_arbiter.sv
// Shares one external combinational PMP checker between IFU, LSU and PTW.
// One request in flight: accept -> CHECK (repeated on CSR change) -> RESP until consumed.
module orv64_pmp_arbiter
  import orv64_typedef_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  orv64_paddr_t       [N_REQ-1:0]      req_paddr,
  input  orv64_access_type_t [N_REQ-1:0]      req_access_type,
  input  cpu_byte_mask_t     [N_REQ-1:0]      req_byte_width,
  output logic [N_REQ-1:0]                    resp_valid,
  input  logic [N_REQ-1:0]                    resp_ready,
  output logic                                resp_excp_valid,
  output orv64_excp_cause_t                   resp_excp_cause,
  input  logic                                pmp_cfg_chg,
  input  logic                                flush,
  output logic                                chk_paddr_valid,
  output orv64_paddr_t                        chk_paddr,
  output orv64_access_type_t                  chk_access_type,
  output cpu_byte_mask_t                      chk_byte_width,
  input  logic                                chk_excp_valid,
  input  orv64_excp_cause_t                   chk_excp_cause
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  pmp_arb_state_e     state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  orv64_paddr_t       paddr_q, paddr_d;
  orv64_access_type_t type_q, type_d;
  cpu_byte_mask_t     width_q, width_d;
  logic               excp_valid_q, excp_valid_d;
  orv64_excp_cause_t  excp_cause_q, excp_cause_d;

  logic [N_REQ-1:0]   grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               resp_active;

  orv64_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  // A flush in RESP suppresses the response in that very cycle.
  assign resp_active = (state_q == PMP_ARB_RESP) && !flush;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    idx_d           = idx_q;
    paddr_d         = paddr_q;
    type_d          = type_q;
    width_d         = width_q;
    excp_valid_d    = excp_valid_q;
    excp_cause_d    = excp_cause_q;
    req_ready       = '0;
    resp_valid      = '0;
    chk_paddr_valid = 1'b0;

    case (state_q)
      PMP_ARB_IDLE: begin
        if (!flush && (|req_valid)) begin
          req_ready    = grant;
          last_grant_d = grant_idx;
          idx_d        = grant_idx;
          paddr_d      = req_paddr[grant_idx];
          type_d       = req_access_type[grant_idx];
          width_d      = req_byte_width[grant_idx];
          state_d      = PMP_ARB_CHECK;
        end
      end
      PMP_ARB_CHECK: begin
        chk_paddr_valid = 1'b1;
        if (flush) begin
          state_d = PMP_ARB_IDLE;
        end else if (!pmp_cfg_chg) begin
          // A result computed against CSRs being rewritten is stale; retry next cycle.
          excp_valid_d = chk_excp_valid;
          excp_cause_d = chk_excp_cause;
          state_d      = PMP_ARB_RESP;
        end
      end
      PMP_ARB_RESP: begin
        if (flush) begin
          state_d = PMP_ARB_IDLE;
        end else begin
          resp_valid[idx_q] = 1'b1;
          if (resp_ready[idx_q]) state_d = PMP_ARB_IDLE;
        end
      end
      default: state_d = PMP_ARB_IDLE;
    endcase
  end

  assign resp_excp_valid = resp_active ? excp_valid_q : 1'b0;
  assign resp_excp_cause = resp_active ? excp_cause_q : ORV64_EXCP_CAUSE_NONE;
  assign chk_paddr       = paddr_q;
  assign chk_access_type = type_q;
  assign chk_byte_width  = width_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= PMP_ARB_IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      idx_q        <= '0;
      paddr_q      <= '0;
      type_q       <= ORV64_ACCESS_FETCH;
      width_q      <= '0;
      excp_valid_q <= 1'b0;
      excp_cause_q <= ORV64_EXCP_CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      paddr_q      <= paddr_d;
      type_q       <= type_d;
      width_q      <= width_d;
      excp_valid_q <= excp_valid_d;
      excp_cause_q <= excp_cause_d;
    end
  end

endmodule

// File: tb/tb_orv64_pmp_arbiter.sv
// Directed bench for orv64_pmp_arbiter: a transaction-level model checks every
// cycle, and per-scenario literal expectations pin that model.
module tb_orv64_pmp_arbiter;
  import orv64_typedef_pkg::*;

  logic                       clk;
  logic                       rstn;
  logic [2:0]                 req_valid;
  logic [2:0]                 req_ready;
  orv64_paddr_t       [2:0]   req_paddr;
  orv64_access_type_t [2:0]   req_access_type;
  cpu_byte_mask_t     [2:0]   req_byte_width;
  logic [2:0]                 resp_valid;
  logic [2:0]                 resp_ready;
  logic                       resp_excp_valid;
  orv64_excp_cause_t          resp_excp_cause;
  logic                       pmp_cfg_chg;
  logic                       flush;
  logic                       chk_paddr_valid;
  orv64_paddr_t               chk_paddr;
  orv64_access_type_t         chk_access_type;
  cpu_byte_mask_t             chk_byte_width;
  logic                       chk_excp_valid;
  orv64_excp_cause_t          chk_excp_cause;

  int checks   = 0;
  int failures = 0;

  orv64_pmp_arbiter #(.N_REQ(3)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_paddr       (req_paddr),
    .req_access_type (req_access_type),
    .req_byte_width  (req_byte_width),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_excp_valid (resp_excp_valid),
    .resp_excp_cause (resp_excp_cause),
    .pmp_cfg_chg     (pmp_cfg_chg),
    .flush           (flush),
    .chk_paddr_valid (chk_paddr_valid),
    .chk_paddr       (chk_paddr),
    .chk_access_type (chk_access_type),
    .chk_byte_width  (chk_byte_width),
    .chk_excp_valid  (chk_excp_valid),
    .chk_excp_cause  (chk_excp_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic int rr_pick(input logic [2:0] v, input int last);
    for (int off = 1; off <= 3; off++) begin
      int c;
      c = (last + off) % 3;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Transaction-level model: an in-flight record that is either awaiting a
  // stable checker verdict or holding the verdict for its requester.
  bit                 m_busy;
  bit                 m_checked;
  int                 m_idx;
  int                 m_last;
  orv64_paddr_t       m_paddr;
  orv64_access_type_t m_type;
  cpu_byte_mask_t     m_width;
  logic               m_ev;
  orv64_excp_cause_t  m_ec;

  initial begin
    m_busy = 0; m_checked = 0; m_idx = 0; m_last = 2;
    m_paddr = '0; m_type = ORV64_ACCESS_FETCH; m_width = '0; m_ev = 1'b0; m_ec = '0;
    forever begin
      logic [2:0]        e_ready;
      logic [2:0]        e_resp;
      logic              e_chk;
      logic              e_ev;
      orv64_excp_cause_t e_ec;
      int                p;
      @(negedge clk);
      if (!rstn) begin
        check("model_rst_req_ready", req_ready, 3'b000);
        check("model_rst_resp_valid", resp_valid, 3'b000);
        check("model_rst_chk_valid", chk_paddr_valid, 1'b0);
        check("model_rst_excp_valid", resp_excp_valid, 1'b0);
        check("model_rst_excp_cause", resp_excp_cause, 4'd0);
        m_busy = 0; m_checked = 0; m_last = 2;
      end else begin
        e_ready = '0; e_resp = '0; e_chk = 1'b0; e_ev = 1'b0; e_ec = '0; p = -1;
        if (!m_busy) begin
          p = rr_pick(req_valid, m_last);
          if (!flush && p >= 0) e_ready[p] = 1'b1;
        end else if (!m_checked) begin
          e_chk = 1'b1;
        end else if (!flush) begin
          e_resp[m_idx] = 1'b1;
          e_ev = m_ev;
          e_ec = m_ec;
        end
        check("model_req_ready", req_ready, e_ready);
        check("model_resp_valid", resp_valid, e_resp);
        check("model_chk_valid", chk_paddr_valid, e_chk);
        check("model_excp_valid", resp_excp_valid, e_ev);
        check("model_excp_cause", resp_excp_cause, e_ec);
        if (e_chk) begin
          check("model_chk_paddr", chk_paddr, m_paddr);
          check("model_chk_type", chk_access_type, m_type);
          check("model_chk_width", chk_byte_width, m_width);
        end
        if (flush) begin
          m_busy = 0;
        end else if (!m_busy) begin
          if (p >= 0) begin
            m_busy = 1; m_checked = 0; m_idx = p; m_last = p;
            m_paddr = req_paddr[p]; m_type = req_access_type[p]; m_width = req_byte_width[p];
          end
        end else if (!m_checked) begin
          if (!pmp_cfg_chg) begin
            m_checked = 1; m_ev = chk_excp_valid; m_ec = chk_excp_cause;
          end
        end else if (resp_ready[m_idx]) begin
          m_busy = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int               rcyc[$];
    logic [2:0]       rval[$];
    logic [2:0]       exp_rr [4];
    int               n;

    rstn = 1'b0; req_valid = '0; resp_ready = '0; flush = 1'b0; pmp_cfg_chg = 1'b0;
    chk_excp_valid = 1'b0; chk_excp_cause = ORV64_EXCP_CAUSE_NONE;
    for (int i = 0; i < 3; i++) begin
      req_paddr[i]       = 56'h1000 * (i + 1);
      req_access_type[i] = ORV64_ACCESS_FETCH;
      req_byte_width[i]  = 8'h0F;
    end
    req_access_type[1] = ORV64_ACCESS_LOAD;
    req_access_type[2] = ORV64_ACCESS_STORE;

    step();
    at_neg();
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_chk_paddr", chk_paddr, 64'h0);
    step();
    rstn = 1'b1;

    // All three requesters valid continuously, responses consumed at once
    req_valid = 3'b111; resp_ready = 3'b111;
    for (int k = 0; k < 12; k++) begin
      at_neg();
      if (|resp_valid) begin
        rcyc.push_back(k);
        rval.push_back(resp_valid);
      end
      step();
    end
    req_valid = 3'b000;
    exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100; exp_rr[3] = 3'b001;
    check("rr_resp_count", rcyc.size(), 4);
    n = (rcyc.size() < 4) ? rcyc.size() : 4;
    for (int i = 0; i < n; i++) begin
      check("rr_grant_order", rval[i], exp_rr[i]);
      if (i > 0) check("rr_resp_spacing", rcyc[i] - rcyc[i-1], 3);
    end
    if (n > 0) check("rr_first_resp_cycle", rcyc[0], 2);

    // Single LSU load at 0x8000_0000, width 8, no fault
    req_valid = 3'b010; req_paddr[1] = 56'h8000_0000;
    req_access_type[1] = ORV64_ACCESS_LOAD; req_byte_width[1] = 8'hFF;
    at_neg();
    check("lsu_ready_T", req_ready, 3'b010);
    step();
    req_valid = 3'b000;
    at_neg();
    check("lsu_chk_valid_T1", chk_paddr_valid, 1'b1);
    check("lsu_chk_paddr_T1", chk_paddr, 64'h8000_0000);
    check("lsu_chk_width_T1", chk_byte_width, 8'hFF);
    check("lsu_resp_T1", resp_valid, 3'b000);
    step();
    at_neg();
    check("lsu_resp_T2", resp_valid, 3'b010);
    check("lsu_excp_T2", resp_excp_valid, 1'b0);
    check("lsu_chk_valid_T2", chk_paddr_valid, 1'b0);
    step();

    // CSR change during CHECK at T+1 and T+2; T+3 verdict must be the one kept
    req_valid = 3'b100; req_paddr[2] = 56'h2000;
    req_access_type[2] = ORV64_ACCESS_LOAD; req_byte_width[2] = 8'h0F;
    at_neg();
    check("cfg_ready_T", req_ready, 3'b100);
    step();
    req_valid = 3'b000; pmp_cfg_chg = 1'b1;
    chk_excp_valid = 1'b0; chk_excp_cause = ORV64_EXCP_CAUSE_NONE;
    at_neg();
    check("cfg_chk_valid_T1", chk_paddr_valid, 1'b1);
    step();
    chk_excp_valid = 1'b1; chk_excp_cause = ORV64_EXCP_STORE_ACCESS_FAULT;
    at_neg();
    check("cfg_chk_valid_T2", chk_paddr_valid, 1'b1);
    check("cfg_resp_T2", resp_valid, 3'b000);
    step();
    pmp_cfg_chg = 1'b0; chk_excp_valid = 1'b1; chk_excp_cause = ORV64_EXCP_LOAD_ACCESS_FAULT;
    at_neg();
    check("cfg_chk_valid_T3", chk_paddr_valid, 1'b1);
    check("cfg_resp_T3", resp_valid, 3'b000);
    step();
    pmp_cfg_chg = 1'b1; chk_excp_valid = 1'b0; chk_excp_cause = ORV64_EXCP_CAUSE_NONE;
    at_neg();
    check("cfg_resp_T4", resp_valid, 3'b100);
    check("cfg_excp_valid_T4", resp_excp_valid, 1'b1);
    check("cfg_excp_cause_T4", resp_excp_cause, 4'd5);
    step();
    pmp_cfg_chg = 1'b0;

    // IFU store fault held while resp_ready stays low for 5 cycles
    resp_ready = 3'b000; req_valid = 3'b001; req_paddr[0] = 56'h3000;
    req_access_type[0] = ORV64_ACCESS_STORE;
    at_neg();
    check("hold_ready_T", req_ready, 3'b001);
    step();
    req_valid = 3'b000; chk_excp_valid = 1'b1; chk_excp_cause = ORV64_EXCP_STORE_ACCESS_FAULT;
    at_neg();
    step();
    chk_excp_valid = 1'b0; chk_excp_cause = ORV64_EXCP_CAUSE_NONE;
    for (int j = 0; j < 5; j++) begin
      resp_ready = (j == 2) ? 3'b010 : 3'b000;
      at_neg();
      check("hold_resp_valid", resp_valid, 3'b001);
      check("hold_excp_valid", resp_excp_valid, 1'b1);
      check("hold_excp_cause", resp_excp_cause, 4'd7);
      step();
    end
    resp_ready = 3'b001;
    at_neg();
    check("hold_resp_handshake", resp_valid, 3'b001);
    step();
    resp_ready = 3'b000;
    at_neg();
    check("hold_idle_resp", resp_valid, 3'b000);
    check("hold_idle_chk", chk_paddr_valid, 1'b0);
    step();

    // flush in IDLE blocks the grant
    req_valid = 3'b001; flush = 1'b1;
    at_neg();
    check("flush_idle_ready", req_ready, 3'b000);
    step();

    // flush in CHECK
    flush = 1'b0; req_valid = 3'b010;
    at_neg();
    check("flushc_ready_T", req_ready, 3'b010);
    step();
    req_valid = 3'b000; flush = 1'b1;
    at_neg();
    check("flushc_resp_T1", resp_valid, 3'b000);
    step();
    flush = 1'b0; req_valid = 3'b010; resp_ready = 3'b111;
    at_neg();
    check("flushc_idle_chk", chk_paddr_valid, 1'b0);
    check("flushc_resp_T2", resp_valid, 3'b000);
    check("flushc_new_accept", req_ready, 3'b010);
    step();
    req_valid = 3'b000;
    step();
    at_neg();
    check("flushc_new_resp", resp_valid, 3'b010);
    step();

    // flush in RESP
    req_valid = 3'b100;
    at_neg();
    check("flushr_ready_T", req_ready, 3'b100);
    step();
    req_valid = 3'b000; resp_ready = 3'b000;
    step();
    flush = 1'b1;
    at_neg();
    check("flushr_resp_T2", resp_valid, 3'b000);
    check("flushr_excp_T2", resp_excp_valid, 1'b0);
    step();
    flush = 1'b0; req_valid = 3'b100;
    at_neg();
    check("flushr_resp_T3", resp_valid, 3'b000);
    check("flushr_new_accept", req_ready, 3'b100);
    step();
    req_valid = 3'b000; resp_ready = 3'b111;
    step();
    at_neg();
    check("flushr_new_resp", resp_valid, 3'b100);
    step();

    // Asynchronous reset while a response is pending
    req_valid = 3'b010; resp_ready = 3'b000;
    at_neg();
    check("rstr_ready_T", req_ready, 3'b010);
    step();
    req_valid = 3'b000;
    step();
    at_neg();
    check("rstr_resp_T2", resp_valid, 3'b010);
    #2;
    rstn = 1'b0;
    #1;
    check("rstr_async_resp", resp_valid, 3'b000);
    check("rstr_async_ready", req_ready, 3'b000);
    check("rstr_async_chk", chk_paddr_valid, 1'b0);
    check("rstr_async_excp", resp_excp_valid, 1'b0);
    check("rstr_async_paddr", chk_paddr, 64'h0);
    step();
    step();
    rstn = 1'b1; req_valid = 3'b111; resp_ready = 3'b111;
    at_neg();
    check("rstr_first_grant", req_ready, 3'b001);
    step();
    req_valid = 3'b000;
    step();
    at_neg();
    check("rstr_first_resp", resp_valid, 3'b001);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/orv64_pmp_arbiter.md
ORV64_PMP_ARBITER -- requirements
Module: orv64_pmp_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (0=IFU, 1=LSU, 2=PTW).
REQ-002 SHALL have port clk  input  1  single clock; all state is rising-edge.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  input  N_REQ  per-requester check request.
REQ-005 SHALL have port req_ready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-006 SHALL have port req_paddr  input  N_REQ x orv64_paddr_t  physical address.
REQ-007 SHALL have port req_access_type  input  N_REQ x orv64_access_type_t  fetch/load/store.
REQ-008 SHALL have port req_byte_width  input  N_REQ x cpu_byte_mask_t  access byte width.
REQ-009 SHALL have port resp_valid  output  N_REQ  per-requester result valid, one-hot or zero.
REQ-010 SHALL have port resp_ready  input  N_REQ  per-requester result consume.
REQ-011 SHALL have port resp_excp_valid  output  1  PMP fault for the responding requester.
REQ-012 SHALL have port resp_excp_cause  output  orv64_excp_cause_t  fault cause.
REQ-013 SHALL have port pmp_cfg_chg  input  1  pulse: pmpcfg/pmpaddr/mstatus.MPRV/prv written this cycle.
REQ-014 SHALL have port flush  input  1  pipeline kill; abandons in-flight request.
REQ-015 SHALL have ports chk_paddr_valid/chk_paddr/chk_access_type/chk_byte_width  output  matching widths  drive the shared checker.
REQ-016 SHALL have ports chk_excp_valid/chk_excp_cause  input  1/orv64_excp_cause_t  combinational checker result.

Function
REQ-017 SHALL implement FSM IDLE, CHECK, RESP.
REQ-018 IDLE: when any req_valid, SHALL grant one requester round-robin starting after last_grant, assert its req_ready combinationally, latch paddr/type/width/index, go to CHECK.
REQ-019 req_ready SHALL be zero outside IDLE and zero while flush is high.
REQ-020 CHECK: SHALL drive chk_paddr_valid=1 with latched fields; if pmp_cfg_chg=0, capture chk_excp_valid/cause and go to RESP.
REQ-021 CHECK with pmp_cfg_chg=1 SHALL discard result and stay in CHECK one more cycle (recheck with new CSRs).
REQ-022 RESP: SHALL assert resp_valid[idx] with registered excp outputs, holding stable until resp_ready[idx]; then go to IDLE.
REQ-023 pmp_cfg_chg in RESP SHALL NOT alter the captured result.
REQ-024 flush in any state SHALL return to IDLE next cycle with no response issued; flush wins over all other events.
REQ-025 last_grant SHALL update only on accept; with single requester, it SHALL be granted on every IDLE cycle it is valid.
REQ-026 Latency: accept cycle T, chk_paddr_valid at T+1, resp_valid at T+2 (no cfg change); max one request in flight.
REQ-027 chk_paddr_valid SHALL be 0 outside CHECK; resp_excp_valid/cause SHALL be 0 when no resp_valid.
REQ-028 resp_ready to a non-responding index SHALL be ignored.

Reset
REQ-029 On rstn low: state=IDLE, last_grant=N_REQ-1 (requester 0 wins first), latched fields, req_ready, resp_valid, chk_paddr_valid, resp_excp_valid/cause all 0.
REQ-030 Reset mid-operation SHALL drop the in-flight request silently.

Structure
REQ-031 FSM state enum and requester-index constants (IFU/LSU/PTW) SHALL live in orv64_typedef_pkg.
REQ-032 Round-robin grant SHALL be a sub-module orv64_rr_arbiter (req, last_grant in; one-hot grant out).
REQ-033 Block SHALL instantiate no checker; it connects externally to orv64_pmp_checker.

Verification
REQ-034 Single LSU load paddr=0x8000_0000, width 8, checker no fault -> req_ready[1] at T, chk_paddr_valid T+1, resp_valid[1] T+2, excp_valid=0.
REQ-035 All three valid continuously, resp_ready tied 1 -> grants 0,1,2,0 in order, each response 3 cycles apart.
REQ-036 pmp_cfg_chg at T+1 and T+2 -> chk_paddr_valid held T+1..T+3, resp_valid at T+4 reflecting T+3 checker result.
REQ-037 Checker fault (store-access cause) with resp_ready low 5 cycles -> resp_valid and cause stable all 5 cycles, IDLE after handshake.
REQ-038 flush in CHECK and separately in RESP -> no resp_valid, IDLE next cycle, new request accepted the cycle after.
REQ-039 rstn asserted during RESP -> all outputs 0 asynchronously, requester 0 granted first after release.
